// File: rtl/noc_pe_ni_pkg.sv
// Shared flit layout and helper functions for the PE-side network interface.
// Holds field offsets, flit packing and saturating counter arithmetic.
package noc_pkg;

   localparam int DATA_W = 32;
   localparam int X_SIZE = 1;
   localparam int Y_SIZE = 1;
   localparam int FLIT_W = X_SIZE + Y_SIZE + DATA_W;
   localparam int SAT_W  = 8;

   localparam int PAYLOAD_LSB = 0;
   localparam int DSTX_LSB    = DATA_W;
   localparam int DSTY_LSB    = DATA_W + X_SIZE;

   function automatic logic [FLIT_W-1:0] build_flit(
      input logic [Y_SIZE-1:0] dst_y,
      input logic [X_SIZE-1:0] dst_x,
      input logic [DATA_W-1:0] payload
   );
      return {dst_y, dst_x, payload};
   endfunction

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
      return (v == {SAT_W{1'b1}}) ? v : v + {{(SAT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/noc_pe_ni_if.sv
// Handshake bundle between the network interface, its PE and its switch port.
// Optional build macro: NOC_NI_STATS_EN adds the packet statistics counters.
interface noc_pe_ni_if #(
   parameter int data_width = 32,
   parameter int x_size     = 1,
   parameter int y_size     = 1,
   parameter int CNT_W      = 8
);
   localparam int total_width = x_size + y_size + data_width;

   logic                   tx_valid;
   logic                   tx_ready;
   logic [x_size-1:0]      tx_dst_x;
   logic [y_size-1:0]      tx_dst_y;
   logic [data_width-1:0]  tx_data;
   logic                   noc_o_valid;
   logic                   noc_i_ready;
   logic [total_width-1:0] noc_o_data;
   logic                   noc_i_valid;
   logic [total_width-1:0] noc_i_data;
   logic                   rx_valid;
   logic                   rx_ready;
   logic [data_width-1:0]  rx_data;
   logic                   rx_overflow;
   logic [CNT_W-1:0]       drop_cnt;
   logic [CNT_W-1:0]       misroute_cnt;
`ifdef NOC_NI_STATS_EN
   logic [31:0]            tx_pkt_cnt;
   logic [31:0]            rx_pkt_cnt;
`endif

   modport slave (
      input  tx_valid, tx_dst_x, tx_dst_y, tx_data, noc_i_ready,
      input  noc_i_valid, noc_i_data, rx_ready,
`ifdef NOC_NI_STATS_EN
      output tx_pkt_cnt, rx_pkt_cnt,
`endif
      output tx_ready, noc_o_valid, noc_o_data, rx_valid, rx_data,
      output rx_overflow, drop_cnt, misroute_cnt
   );

   modport master (
      output tx_valid, tx_dst_x, tx_dst_y, tx_data, noc_i_ready,
      output noc_i_valid, noc_i_data, rx_ready,
`ifdef NOC_NI_STATS_EN
      input  tx_pkt_cnt, rx_pkt_cnt,
`endif
      input  tx_ready, noc_o_valid, noc_o_data, rx_valid, rx_data,
      input  rx_overflow, drop_cnt, misroute_cnt
   );

endinterface

// File: rtl/noc_ni_fifo.sv
// Circular FIFO with wrap-bit pointers and a registered head entry.
// Caller qualifies push (not full, or full with pop) and pop (not empty).
module noc_ni_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [AW:0]      rd_next_s;
   logic [WIDTH-1:0] head_r;

   assign rd_next_s = rd_ptr_r + {{AW{1'b0}}, pop};
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign head  = head_r;

   // Storage and pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
         end
         wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, push};
         rd_ptr_r <= rd_next_s;
      end
   end

   // Head register; bypasses din when the written slot becomes the head
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r <= {WIDTH{1'b0}};
      end else if (push && (rd_next_s == wr_ptr_r)) begin
         head_r <= din;
      end else begin
         head_r <= mem_r[rd_next_s[AW-1:0]];
      end
   end

endmodule

// File: rtl/noc_pe_ni.sv
// PE-side network interface: TX flit packing/buffering and RX capture with drop/misroute tracking.
// Optional build macro: NOC_NI_STATS_EN adds 32-bit tx_pkt_cnt / rx_pkt_cnt.
module noc_pe_ni
   import noc_pkg::*;
#(
   parameter int X           = 2,
   parameter int Y           = 2,
   parameter int x_coord     = 0,
   parameter int y_coord     = 0,
   parameter int data_width  = DATA_W,
   parameter int x_size      = X_SIZE,
   parameter int y_size      = Y_SIZE,
   parameter int total_width = x_size + y_size + data_width,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = SAT_W
) (
   input logic       clk,
   input logic       rst,
   noc_pe_ni_if.slave ifc
);
   localparam logic [x_size-1:0] MY_X = x_size'(x_coord);
   localparam logic [y_size-1:0] MY_Y = y_size'(y_coord);

   if ((x_coord >= X) || (y_coord >= Y) || (DEPTH < 2)) begin : g_bad_cfg
      $error("noc_pe_ni: node coordinates outside the mesh or DEPTH < 2");
   end

   logic                   run_r;
   logic                   tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
   logic [total_width-1:0] tx_flit_s, tx_head_s;
   logic                   rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;
   logic [data_width-1:0]  rx_head_s;
   logic                   drop_s, misroute_s;
   logic                   rx_overflow_r;
   logic [CNT_W-1:0]       drop_cnt_r, misroute_cnt_r;

   assign tx_flit_s = build_flit(ifc.tx_dst_y, ifc.tx_dst_x, ifc.tx_data);
   assign tx_push_s = ifc.tx_valid & run_r & ~tx_full_s;
   assign tx_pop_s  = ~tx_empty_s & ifc.noc_i_ready;

   noc_ni_fifo #(.DEPTH(DEPTH), .WIDTH(total_width)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push_s), .din(tx_flit_s),
      .pop(tx_pop_s), .full(tx_full_s), .empty(tx_empty_s), .head(tx_head_s)
   );

   // A full RX FIFO still accepts when the PE drains the head in the same cycle
   assign rx_pop_s   = ~rx_empty_s & ifc.rx_ready;
   assign rx_push_s  = ifc.noc_i_valid & (~rx_full_s | rx_pop_s);
   assign drop_s     = ifc.noc_i_valid & rx_full_s & ~rx_pop_s;
   assign misroute_s = ifc.noc_i_valid &
                       ((ifc.noc_i_data[DSTX_LSB +: x_size] != MY_X) ||
                        (ifc.noc_i_data[DSTY_LSB +: y_size] != MY_Y));

   noc_ni_fifo #(.DEPTH(DEPTH), .WIDTH(data_width)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push_s),
      .din(ifc.noc_i_data[PAYLOAD_LSB +: data_width]),
      .pop(rx_pop_s), .full(rx_full_s), .empty(rx_empty_s), .head(rx_head_s)
   );

   assign ifc.tx_ready     = run_r & ~tx_full_s;
   assign ifc.noc_o_valid  = ~tx_empty_s;
   assign ifc.noc_o_data   = tx_head_s;
   assign ifc.rx_valid     = ~rx_empty_s;
   assign ifc.rx_data      = rx_head_s;
   assign ifc.rx_overflow  = rx_overflow_r;
   assign ifc.drop_cnt     = drop_cnt_r;
   assign ifc.misroute_cnt = misroute_cnt_r;

   // Holds tx_ready low until the first clock after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

   // Sticky overflow flag and saturating drop/misroute counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_overflow_r  <= 1'b0;
         drop_cnt_r     <= {CNT_W{1'b0}};
         misroute_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (drop_s) begin
            rx_overflow_r <= 1'b1;
            drop_cnt_r    <= sat_inc(drop_cnt_r);
         end
         if (misroute_s) begin
            misroute_cnt_r <= sat_inc(misroute_cnt_r);
         end
      end
   end

`ifdef NOC_NI_STATS_EN
   logic [31:0] tx_pkt_cnt_r, rx_pkt_cnt_r;

   assign ifc.tx_pkt_cnt = tx_pkt_cnt_r;
   assign ifc.rx_pkt_cnt = rx_pkt_cnt_r;

   // Wrap-around packet counters for flits sent to the NoC and flits buffered for the PE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_pkt_cnt_r <= 32'd0;
         rx_pkt_cnt_r <= 32'd0;
      end else begin
         tx_pkt_cnt_r <= tx_pkt_cnt_r + {31'd0, tx_pop_s};
         rx_pkt_cnt_r <= rx_pkt_cnt_r + {31'd0, rx_push_s};
      end
   end
`endif

endmodule

// File: tb/tb_noc_pe_ni.sv
// Directed self-checking bench for noc_pe_ni: reset, TX path, RX overflow, misroute, mid-traffic reset.
module tb_noc_pe_ni;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_rx [4];

   always #5 clk = ~clk;

   noc_pe_ni_if #(.data_width(32), .x_size(1), .y_size(1), .CNT_W(8)) ifc ();

   noc_pe_ni #(
      .X(2), .Y(2), .x_coord(0), .y_coord(0), .data_width(32), .x_size(1),
      .y_size(1), .total_width(34), .DEPTH(4), .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ifc(ifc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst             = 1'b1;
      ifc.tx_valid    = 1'b0;
      ifc.tx_dst_x    = 1'b0;
      ifc.tx_dst_y    = 1'b0;
      ifc.tx_data     = 32'd0;
      ifc.noc_i_ready = 1'b0;
      ifc.noc_i_valid = 1'b0;
      ifc.noc_i_data  = 34'd0;
      ifc.rx_ready    = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_tx_ready", 64'(ifc.tx_ready), 64'd0);
      chk("rst_noc_o_valid", 64'(ifc.noc_o_valid), 64'd0);
      chk("rst_rx_valid", 64'(ifc.rx_valid), 64'd0);
      chk("rst_rx_overflow", 64'(ifc.rx_overflow), 64'd0);
      chk("rst_drop_cnt", 64'(ifc.drop_cnt), 64'd0);
      chk("rst_misroute_cnt", 64'(ifc.misroute_cnt), 64'd0);
      rst = 1'b0;
      step();
      chk("post_rst_tx_ready", 64'(ifc.tx_ready), 64'd1);

      // TX basic: flit visible the cycle after the push, popped while ready is high
      ifc.noc_i_ready = 1'b1;
      ifc.tx_valid    = 1'b1;
      ifc.tx_dst_x    = 1'b1;
      ifc.tx_dst_y    = 1'b1;
      ifc.tx_data     = 32'hDEADBEEF;
      step();
      ifc.tx_valid = 1'b0;
      chk("tx_basic_valid", 64'(ifc.noc_o_valid), 64'd1);
      chk("tx_basic_data", 64'(ifc.noc_o_data), 64'h3_DEADBEEF);
      step();
      chk("tx_basic_popped", 64'(ifc.noc_o_valid), 64'd0);

      // TX backpressure: four pushes fill the FIFO, a fifth is refused
      ifc.noc_i_ready = 1'b0;
      ifc.tx_dst_x    = 1'b1;
      ifc.tx_dst_y    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ifc.tx_valid = 1'b1;
         ifc.tx_data  = 32'h100 + 32'(i);
         step();
      end
      chk("tx_bp_ready_full", 64'(ifc.tx_ready), 64'd0);
      chk("tx_bp_head", 64'(ifc.noc_o_data), 64'h1_00000100);
      ifc.tx_data = 32'h104;
      step();
      ifc.tx_valid = 1'b0;
      chk("tx_bp_ready_still", 64'(ifc.tx_ready), 64'd0);
      chk("tx_bp_head_stable", 64'(ifc.noc_o_data), 64'h1_00000100);
      ifc.noc_i_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("tx_drain_valid", 64'(ifc.noc_o_valid), 64'd1);
         chk("tx_drain_data", 64'(ifc.noc_o_data), 64'h1_00000100 + 64'(i));
         step();
      end
      chk("tx_drain_empty", 64'(ifc.noc_o_valid), 64'd0);
      chk("tx_drain_ready", 64'(ifc.tx_ready), 64'd1);
      ifc.noc_i_ready = 1'b0;

      // RX overflow: six flits to (0,0) with the PE stalled
      ifc.rx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ifc.noc_i_valid = 1'b1;
         ifc.noc_i_data  = {2'b00, 32'hA0 + 32'(i)};
         step();
         if (i == 0) begin
            chk("rx_latency_valid", 64'(ifc.rx_valid), 64'd1);
         end
      end
      ifc.noc_i_valid = 1'b0;
      chk("rx_ovf_drop_cnt", 64'(ifc.drop_cnt), 64'd2);
      chk("rx_ovf_flag", 64'(ifc.rx_overflow), 64'd1);
      chk("rx_ovf_misroute", 64'(ifc.misroute_cnt), 64'd0);
      chk("rx_ovf_head", 64'(ifc.rx_data), 64'hA0);

      // RX full with a same-cycle pop: the incoming flit is written, nothing dropped
      ifc.rx_ready    = 1'b1;
      ifc.noc_i_valid = 1'b1;
      ifc.noc_i_data  = {2'b00, 32'hA6};
      step();
      ifc.rx_ready    = 1'b0;
      ifc.noc_i_valid = 1'b0;
      chk("rx_fullpop_drop_cnt", 64'(ifc.drop_cnt), 64'd2);
      chk("rx_fullpop_head", 64'(ifc.rx_data), 64'hA1);
      exp_rx[0] = 32'hA1;
      exp_rx[1] = 32'hA2;
      exp_rx[2] = 32'hA3;
      exp_rx[3] = 32'hA6;
      ifc.rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("rx_drain_valid", 64'(ifc.rx_valid), 64'd1);
         chk("rx_drain_data", 64'(ifc.rx_data), 64'(exp_rx[i]));
         step();
      end
      chk("rx_drain_empty", 64'(ifc.rx_valid), 64'd0);
      ifc.rx_ready = 1'b0;

      // Misroute: flit for (1,0) arrives at node (0,0) and is still buffered
      ifc.noc_i_valid = 1'b1;
      ifc.noc_i_data  = {1'b0, 1'b1, 32'h1};
      step();
      ifc.noc_i_valid = 1'b0;
      chk("misroute_cnt", 64'(ifc.misroute_cnt), 64'd1);
      chk("misroute_rx_valid", 64'(ifc.rx_valid), 64'd1);
      chk("misroute_rx_data", 64'(ifc.rx_data), 64'h1);
      ifc.rx_ready = 1'b1;
      step();
      ifc.rx_ready = 1'b0;
      chk("misroute_drained", 64'(ifc.rx_valid), 64'd0);

      // Drop counter saturation: 4 written, 260 more dropped on top of 2
      for (int i = 0; i < 264; i++) begin
         ifc.noc_i_valid = 1'b1;
         ifc.noc_i_data  = {2'b00, 32'hB0 + 32'(i)};
         step();
      end
      ifc.noc_i_valid = 1'b0;
      chk("drop_cnt_saturated", 64'(ifc.drop_cnt), 64'd255);
      chk("misroute_unchanged", 64'(ifc.misroute_cnt), 64'd1);
      chk("sat_rx_head", 64'(ifc.rx_data), 64'hB0);

      // Reset mid-traffic with two entries in each FIFO
      ifc.rx_ready = 1'b1;
      step();
      step();
      ifc.rx_ready = 1'b0;
      ifc.tx_valid = 1'b1;
      ifc.tx_data  = 32'h55;
      step();
      ifc.tx_data  = 32'h66;
      step();
      ifc.tx_valid = 1'b0;
      chk("pre_rst_noc_o_valid", 64'(ifc.noc_o_valid), 64'd1);
      chk("pre_rst_rx_data", 64'(ifc.rx_data), 64'hB2);
      chk("pre_rst_tx_ready", 64'(ifc.tx_ready), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_noc_o_valid", 64'(ifc.noc_o_valid), 64'd0);
      chk("async_rst_rx_valid", 64'(ifc.rx_valid), 64'd0);
      chk("async_rst_tx_ready", 64'(ifc.tx_ready), 64'd0);
      chk("async_rst_overflow", 64'(ifc.rx_overflow), 64'd0);
      chk("async_rst_drop_cnt", 64'(ifc.drop_cnt), 64'd0);
      chk("async_rst_misroute", 64'(ifc.misroute_cnt), 64'd0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("post_rst_discarded_tx", 64'(ifc.noc_o_valid), 64'd0);
      chk("post_rst_discarded_rx", 64'(ifc.rx_valid), 64'd0);
      chk("post_rst_ready_again", 64'(ifc.tx_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
